// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with same-cycle write-to-read bypass,
// a per-register busy scoreboard and a sequential clear engine.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset (zeroes array and busy, returns to idle)
//   init_req   start sequential clear of x1..x(NREGS-1)
//   ready      1 while idle (writes and busy_set accepted)
//   we         per-port write enable
//   waddr      write addresses, port i at [i*AW +: AW]
//   wdata      write data, port i at [i*XLEN +: XLEN]
//   raddr      read addresses, port j at [j*AW +: AW]
//   rdata      read data, port j at [j*XLEN +: XLEN] (combinational)
//   busy_set   mark busy_addr as having a pending producer
//   busy_addr  register to mark busy
//   busy       scoreboard, bit r = register r pending
module regfile_mp #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRP    = 2,
  parameter int unsigned NWP    = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_req,
  output logic                 ready,
  input  logic [NWP-1:0]       we,
  input  logic [NWP*AW-1:0]    waddr,
  input  logic [NWP*XLEN-1:0]  wdata,
  input  logic [NRP*AW-1:0]    raddr,
  output logic [NRP*XLEN-1:0]  rdata,
  input  logic                 busy_set,
  input  logic [AW-1:0]        busy_addr,
  output logic [NREGS-1:0]     busy
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   regs_d [NREGS];

  // Unpacked views of the packed port buses.
  logic [AW-1:0]     waddr_a [NWP];
  logic [XLEN-1:0]   wdata_a [NWP];
  logic [AW-1:0]     raddr_a [NRP];
  logic [XLEN-1:0]   rdata_a [NRP];

  for (genvar i = 0; i < NWP; i++) begin : gen_wport
    assign waddr_a[i] = waddr[i*AW +: AW];
    assign wdata_a[i] = wdata[i*XLEN +: XLEN];
  end

  for (genvar j = 0; j < NRP; j++) begin : gen_rport
    assign raddr_a[j]              = raddr[j*AW +: AW];
    assign rdata[j*XLEN +: XLEN]   = rdata_a[j];
  end

  assign ready = (state_q == StIdle);
  assign busy  = busy_q;

  // Next-state: FSM, clear counter, array and scoreboard.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
    end

    case (state_q)
      StIdle: begin
        if (init_req) begin
          // Entering clear: scoreboard wiped, no write commits on this edge.
          state_d = StClear;
          cnt_d   = AW'(1);
          busy_d  = '0;
        end else begin
          // Ascending port order: the highest-index port targeting a register wins.
          for (int i = 0; i < NWP; i++) begin
            if (we[i] && (waddr_a[i] != '0)) begin
              regs_d[waddr_a[i]] = wdata_a[i];
              busy_d[waddr_a[i]] = 1'b0;
            end
          end
          // Applied after the write clears so a newly issued producer wins.
          if (busy_set && (busy_addr != '0)) begin
            busy_d[busy_addr] = 1'b1;
          end
        end
      end
      StClear: begin
        regs_d[cnt_q] = '0;
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= '0;
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // Combinational read with optional forwarding of same-cycle write data.
  // x0 is never written, so the array read already returns zero for it.
  always_comb begin
    for (int j = 0; j < NRP; j++) begin
      rdata_a[j] = regs_q[raddr_a[j]];
      if ((BYPASS != 0) && (state_q == StIdle) && (raddr_a[j] != '0)) begin
        for (int i = 0; i < NWP; i++) begin
          if (we[i] && (waddr_a[i] == raddr_a[j])) begin
            rdata_a[j] = wdata_a[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed plus randomized bench for regfile_mp. A bypassing and a
// non-bypassing instance share all inputs and are checked against one reference model.
module tb_regfile_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRP   = 2;
  localparam int NWP   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                init_req;
  logic                busy_set;
  logic [AW-1:0]       busy_addr;
  logic [NWP-1:0]      we;
  logic [NWP*AW-1:0]   waddr;
  logic [NWP*XLEN-1:0] wdata;
  logic [NRP*AW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rdata, rdata_nb;
  logic                ready, ready_nb;
  logic [NREGS-1:0]    busy, busy_nb;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .init_req(init_req), .ready(ready), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata), .busy_set(busy_set),
    .busy_addr(busy_addr), .busy(busy)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .init_req(init_req), .ready(ready_nb), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata_nb), .busy_set(busy_set),
    .busy_addr(busy_addr), .busy(busy_nb)
  );

  always #50 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: architectural registers, scoreboard, clear progress.
  logic [XLEN-1:0]  m_regs [NREGS];
  logic [NREGS-1:0] m_busy;
  bit               m_clr;
  int               m_ptr;

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    if (rst) begin
      for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
      m_busy = '0;
      m_clr  = 0;
    end else if (m_clr) begin
      m_regs[m_ptr] = '0;
      if (m_ptr == NREGS - 1) m_clr = 0;
      else m_ptr++;
    end else if (init_req) begin
      m_busy = '0;
      m_clr  = 1;
      m_ptr  = 1;
    end else begin
      for (int i = 0; i < NWP; i++) begin
        int a;
        a = int'(waddr[i*AW +: AW]);
        if (we[i] && a != 0) begin
          m_regs[a] = wdata[i*XLEN +: XLEN];
          m_busy[a] = 1'b0;
        end
      end
      if (busy_set && busy_addr != 0) m_busy[busy_addr] = 1'b1;
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input int a, input bit byp);
    logic [XLEN-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
    if (byp && !m_clr) begin
      for (int i = 0; i < NWP; i++)
        if (we[i] && int'(waddr[i*AW +: AW]) == a) v = wdata[i*XLEN +: XLEN];
    end
    return v;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".ready"}, XLEN'(ready), XLEN'(!m_clr));
    check({tag, ".ready_nb"}, XLEN'(ready_nb), XLEN'(!m_clr));
    check({tag, ".busy"}, XLEN'(busy), XLEN'(m_busy));
    check({tag, ".busy_nb"}, XLEN'(busy_nb), XLEN'(m_busy));
    for (int j = 0; j < NRP; j++) begin
      int a;
      a = int'(raddr[j*AW +: AW]);
      check($sformatf("%s.rd%0d[x%0d]", tag, j, a), rdata[j*XLEN +: XLEN], exp_rd(a, 1));
      check($sformatf("%s.rdnb%0d[x%0d]", tag, j, a), rdata_nb[j*XLEN +: XLEN],
            exp_rd(a, 0));
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    rst = 0; init_req = 0; busy_set = 0; busy_addr = '0;
    we = '0; waddr = '0; wdata = '0;
  endtask

  task automatic set_write(input int p, input int a, input logic [XLEN-1:0] d);
    we[p] = 1'b1;
    waddr[p*AW +: AW] = AW'(a);
    wdata[p*XLEN +: XLEN] = d;
  endtask

  // Sweep every address through the read ports without a clock edge.
  task automatic read_all(input string tag);
    for (int a = 0; a < NREGS; a += NRP) begin
      for (int j = 0; j < NRP; j++) raddr[j*AW +: AW] = AW'(a + j);
      #1;
      check_all(tag);
    end
  endtask

  task automatic fill_regs(input logic [XLEN-1:0] base);
    idle_inputs();
    for (int a = 1; a < NREGS; a += 2) begin
      set_write(0, a, base + XLEN'(a));
      if (a + 1 < NREGS) set_write(1, a + 1, base + XLEN'(a + 1));
      tick("fill");
      we = '0;
    end
  endtask

  int lowcnt;

  initial begin
    for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
    m_busy = '0; m_clr = 0; m_ptr = 0;
    idle_inputs();
    raddr = '0;
    rst = 1;
    tick("rst0");
    rst = 0;

    // Randomized traffic; narrow address range some cycles to force collisions.
    for (int n = 0; n < 300; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 3) == 0);
      we = NWP'($urandom);
      for (int i = 0; i < NWP; i++) begin
        waddr[i*AW +: AW] = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
        wdata[i*XLEN +: XLEN] = {$urandom, $urandom};
      end
      for (int j = 0; j < NRP; j++)
        raddr[j*AW +: AW] = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      busy_set  = $urandom_range(0, 1) == 1;
      busy_addr = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      init_req  = ($urandom_range(0, 60) == 0);
      #1;
      check_all("rand_comb");
      tick("rand");
    end

    // Reset after random writes clears everything.
    idle_inputs();
    rst = 1;
    tick("rst1");
    rst = 0;
    read_all("rst1_read");
    check("rst1.busy_const", XLEN'(busy), '0);

    // x0 write dropped.
    set_write(0, 0, 64'hDEAD);
    raddr = '0;
    #1; check("x0.comb", rdata[0 +: XLEN], '0);
    tick("x0");
    check("x0.after", rdata[0 +: XLEN], '0);

    // Basic write to x5, visible next cycle.
    idle_inputs();
    set_write(0, 5, 64'h0123_4567_89AB_CDEF);
    raddr[0 +: AW] = 5'd5;
    tick("x5");
    we = '0;
    #1; check("x5.read", rdata[0 +: XLEN], 64'h0123_4567_89AB_CDEF);

    // Bypass and port priority on x7 (old value 0x5).
    set_write(0, 7, 64'h5);
    tick("x7_old");
    we = '0;
    set_write(0, 7, 64'h11);
    set_write(1, 7, 64'h22);
    raddr[0 +: AW] = 5'd7;
    #1;
    check("byp.rdata0", rdata[0 +: XLEN], 64'h22);
    check("nobyp.rdata0", rdata_nb[0 +: XLEN], 64'h5);
    tick("byp");
    we = '0;
    #1;
    check("byp.after", rdata[0 +: XLEN], 64'h22);
    check("nobyp.after", rdata_nb[0 +: XLEN], 64'h22);

    // Scoreboard set / set-wins / clear.
    idle_inputs();
    busy_set = 1; busy_addr = 5'd3;
    tick("bset");
    check("bset.busy", XLEN'(busy), 64'h8);
    set_write(0, 3, 64'h33);
    tick("bset_wr");
    check("bsetwr.busy", XLEN'(busy), 64'h8);
    busy_set = 0;
    tick("bwr");
    we = '0;
    check("bwr.busy", XLEN'(busy), 64'h0);
    busy_set = 1; busy_addr = 5'd0;
    tick("bset_x0");
    check("bsetx0.busy", XLEN'(busy), 64'h0);

    // Clear sequence with a dropped write to an already-cleared register.
    fill_regs(64'hA500_0000_0000_0000);
    busy_set = 1; busy_addr = 5'd9;
    tick("pre_clr_busy");
    busy_set = 0;
    init_req = 1;
    tick("clr_start");
    init_req = 0;
    check("clr.ready_low", XLEN'(ready), '0);
    check("clr.busy_wiped", XLEN'(busy), '0);
    lowcnt = 1;
    while (ready !== 1'b1 && lowcnt < 100) begin
      if (lowcnt == 10) set_write(0, 2, 64'hBAD);
      else we = '0;
      tick("clr");
      if (ready !== 1'b1) lowcnt++;
    end
    check("clr.low_cycles", XLEN'(lowcnt), XLEN'(NREGS - 1));
    we = '0;
    read_all("clr_read");

    // Reset mid-clear, then a normal write.
    fill_regs(64'h5A00_0000_0000_0000);
    init_req = 1;
    tick("clr2_start");
    init_req = 0;
    for (int c = 0; c < 10; c++) tick("clr2");
    rst = 1;
    tick("clr2_rst");
    rst = 0;
    check("clr2.ready", XLEN'(ready), 64'h1);
    read_all("clr2_read");
    set_write(1, 4, 64'hFEED_F00D);
    raddr[AW +: AW] = 5'd4;
    tick("post_rst_wr");
    we = '0;
    #1; check("post_rst.x4", rdata[XLEN +: XLEN], 64'hFEED_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
